dram_ctl: RTL and testbench

- Data-RAM responder for the hxd32 core's dram port; serves the core's combinational loads and byte-enabled stores from an internal word array.
- Also provides a second, handshaked host port for a debug/loader master, e.g. UART boot loader or testbench backdoor.
- Core accesses always win; host accesses are arbitrated around core stores by a small FSM.

---
 rtl/dram_ctl.sv | 179 +++++++++++++++++
 tb/tb_dram_ctl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctl.sv
// dram_ctl: data-RAM responder for the hxd32 core dram port plus a host port.
//
// The core side is a zero-latency combinational load and a byte-enabled store
// that is never stalled. A second host port (debug / loader master) is served
// by a two-state FSM (IDLE, RESP) that slots host writes into cycles where the
// core is not storing.
//
// Host handshake: the master raises host_req_i with host_wr_i, host_addr_i,
// host_wr_data_i and host_wr_byte_en_i stable and keeps them until it sees
// host_gnt_o. host_gnt_o is a single-cycle completion pulse that arrives one
// cycle after the operation was accepted (read captured / write committed).
// host_req_i is ignored during the gnt cycle, so every transaction takes at
// least two cycles. host_rd_data_o is valid with the gnt of a read and holds
// until the next read completes.
//
// Optional feature, macro DRAM_BOUND_CHK_EN: addresses with any bit set above
// the word index are out of range. Out-of-range stores are dropped, loads and
// reads return 0, and a sticky err_o is raised. Without the macro the upper
// address bits are ignored (aliasing) and err_o is tied low.

module dram_ctl #(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] dram_rd_addr_i,
    output logic [XLEN-1:0] dram_rd_data_o,
    input  logic [XLEN-1:0] dram_wr_addr_i,
    input  logic [XLEN-1:0] dram_wr_data_i,
    input  logic [3:0]      dram_wr_byte_en_i,
    input  logic            host_req_i,
    input  logic            host_wr_i,
    input  logic [XLEN-1:0] host_addr_i,
    input  logic [XLEN-1:0] host_wr_data_i,
    input  logic [3:0]      host_wr_byte_en_i,
    output logic            host_gnt_o,
    output logic [XLEN-1:0] host_rd_data_o,
    output logic            err_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Word storage; contents are deliberately not reset.
    logic [XLEN-1:0] mem_q [DEPTH];

    state_e          state_q, state_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic [AW-1:0]   rd_idx, wr_idx, host_idx;
    logic            rd_oob, wr_oob, host_oob;
    logic            core_we, host_we;
    logic            host_cap, host_commit;
    logic [XLEN-1:0] host_rd_word;

    assign rd_idx   = dram_rd_addr_i[AW+1:2];
    assign wr_idx   = dram_wr_addr_i[AW+1:2];
    assign host_idx = host_addr_i[AW+1:2];

    // Byte offsets are ignored: the core already positions the byte lanes.
    logic unused_lo;
    assign unused_lo = ^{dram_rd_addr_i[1:0], dram_wr_addr_i[1:0], host_addr_i[1:0]};

`ifdef DRAM_BOUND_CHK_EN
    assign rd_oob   = |dram_rd_addr_i[XLEN-1:AW+2];
    assign wr_oob   = |dram_wr_addr_i[XLEN-1:AW+2];
    assign host_oob = |host_addr_i[XLEN-1:AW+2];
`else
    assign rd_oob   = 1'b0;
    assign wr_oob   = 1'b0;
    assign host_oob = 1'b0;

    // Upper address bits alias onto the array when bounds checking is off.
    logic unused_hi;
    assign unused_hi = ^{dram_rd_addr_i[XLEN-1:AW+2], dram_wr_addr_i[XLEN-1:AW+2],
                         host_addr_i[XLEN-1:AW+2]};
`endif

    assign core_we = (dram_wr_byte_en_i != 4'b0000) && !wr_oob;
    assign host_we = host_commit && !host_oob;

    assign dram_rd_data_o = rd_oob ? '0 : mem_q[rd_idx];

    // Host read word: array content merged with a same-edge core store per lane.
    always_comb begin
        host_rd_word = mem_q[host_idx];
        for (int b = 0; b < 4; b++) begin
            if (core_we && (wr_idx == host_idx) && dram_wr_byte_en_i[b]) begin
                host_rd_word[8*b +: 8] = dram_wr_data_i[8*b +: 8];
            end
        end
        if (host_oob) begin
            host_rd_word = '0;
        end
    end

    // Host FSM next state: reads go immediately, writes wait for a core-idle cycle
    // unless they carry no byte enables at all.
    always_comb begin
        state_d     = state_q;
        host_cap    = 1'b0;
        host_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_req_i) begin
                    if (!host_wr_i) begin
                        host_cap = 1'b1;
                        state_d  = ST_RESP;
                    end else if ((dram_wr_byte_en_i == 4'b0000) ||
                                 (host_wr_byte_en_i == 4'b0000)) begin
                        host_commit = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_data_d      = host_cap ? host_rd_word : rd_data_q;
    assign host_gnt_o     = (state_q == ST_RESP);
    assign host_rd_data_o = rd_data_q;

    // Host FSM state and captured read data, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Array writes: core store lanes and host commit lanes never overlap in time
    // unless the host write carries no enables.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (core_we && dram_wr_byte_en_i[b]) begin
                mem_q[wr_idx][8*b +: 8] <= dram_wr_data_i[8*b +: 8];
            end
            if (host_we && host_wr_byte_en_i[b]) begin
                mem_q[host_idx][8*b +: 8] <= host_wr_data_i[8*b +: 8];
            end
        end
    end

`ifdef DRAM_BOUND_CHK_EN
    logic err_q, err_d;

    assign err_d = err_q
                 | rd_oob
                 | ((dram_wr_byte_en_i != 4'b0000) && wr_oob)
                 | ((host_cap || host_commit) && host_oob);

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dram_ctl.sv
// tb_dram_ctl: randomized scoreboard bench for dram_ctl.
// A reference memory model tracks every word; host responses are queued with
// the cycle they are due and checked by an independent monitor process.

module tb_dram_ctl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] dram_rd_addr_i;
    logic [31:0] dram_rd_data_o;
    logic [31:0] dram_wr_addr_i;
    logic [31:0] dram_wr_data_i;
    logic [3:0]  dram_wr_byte_en_i;
    logic        host_req_i;
    logic        host_wr_i;
    logic [31:0] host_addr_i;
    logic [31:0] host_wr_data_i;
    logic [3:0]  host_wr_byte_en_i;
    logic        host_gnt_o;
    logic [31:0] host_rd_data_o;
    logic        err_o;

    dram_ctl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .dram_rd_addr_i    (dram_rd_addr_i),
        .dram_rd_data_o    (dram_rd_data_o),
        .dram_wr_addr_i    (dram_wr_addr_i),
        .dram_wr_data_i    (dram_wr_data_i),
        .dram_wr_byte_en_i (dram_wr_byte_en_i),
        .host_req_i        (host_req_i),
        .host_wr_i         (host_wr_i),
        .host_addr_i       (host_addr_i),
        .host_wr_data_i    (host_wr_data_i),
        .host_wr_byte_en_i (host_wr_byte_en_i),
        .host_gnt_o        (host_gnt_o),
        .host_rd_data_o    (host_rd_data_o),
        .err_o             (err_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- model / scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd;
    logic        err_exp;
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    bit          h_pend, h_resp, chk_ld;
    logic        hs_wr;
    logic [31:0] hs_addr, hs_data;
    logic [3:0]  hs_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_oob(input logic [31:0] a);
`ifdef DRAM_BOUND_CHK_EN
        return (a >> (AW + 2)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a);
        if (is_oob(a)) return 32'h0;
        return ref_mem[widx(a)];
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (!is_oob(a) && be != 4'b0) begin
            ref_mem[widx(a)] = (ref_mem[widx(a)] & ~mask) | (d & mask);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] upper;
        upper = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : 32'h0;
        return (upper << (AW + 2)) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic host_start(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be);
        hs_wr   = wr;
        hs_addr = a;
        hs_data = d;
        hs_be   = be;
        h_pend  = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then
    // advance the reference model at the rising edge.
    task automatic drive_cycle(input logic [31:0] ra, input logic [31:0] wa,
                               input logic [31:0] wd, input logic [3:0] wbe);
        bit acc;
        @(negedge clk_i);
        dram_rd_addr_i    = ra;
        dram_wr_addr_i    = wa;
        dram_wr_data_i    = wd;
        dram_wr_byte_en_i = wbe;
        if (h_pend) begin
            host_wr_i         = hs_wr;
            host_addr_i       = hs_addr;
            host_wr_data_i    = hs_data;
            host_wr_byte_en_i = hs_be;
        end
        host_req_i = h_pend | h_resp;
        #2;
        if (chk_ld) check("core_load", dram_rd_data_o, model_load(ra));
        check("err_flag", {31'b0, err_o}, {31'b0, err_exp});
        @(posedge clk_i);
        cyc++;
        acc = 1'b0;
        if (rst_n_i) begin
            if (is_oob(ra)) err_exp = 1'b1;
            if (wbe != 4'b0 && is_oob(wa)) err_exp = 1'b1;
            if (h_resp) h_resp = 1'b0;
            else if (h_pend && (!host_wr_i || wbe == 4'b0 || host_wr_byte_en_i == 4'b0)) acc = 1'b1;
        end
        model_store(wa, wd, wbe);
        if (acc) begin
            if (is_oob(host_addr_i)) err_exp = 1'b1;
            if (host_wr_i) model_store(host_addr_i, host_wr_data_i, host_wr_byte_en_i);
            else last_rd = model_load(host_addr_i);
            exp_q.push_back(last_rd);
            exp_cyc_q.push_back(cyc);
            h_pend = 1'b0;
            h_resp = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(32'h0, 32'h0, 32'h0, 4'h0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_cyc_q.size() != 0 && exp_cyc_q[0] == cyc) begin
                check("host_gnt", {31'b0, host_gnt_o}, 32'd1);
                check("host_rd_data", host_rd_data_o, exp_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end else if (host_gnt_o) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gnt: got 1 expected 0 (cycle %0d)", cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] wbe;
        rst_n_i = 1'b0;
        dram_rd_addr_i = 0; dram_wr_addr_i = 0; dram_wr_data_i = 0; dram_wr_byte_en_i = 0;
        host_req_i = 0; host_wr_i = 0; host_addr_i = 0; host_wr_data_i = 0; host_wr_byte_en_i = 0;
        h_pend = 0; h_resp = 0; chk_ld = 0; last_rd = 0; err_exp = 0;
        hs_wr = 0; hs_addr = 0; hs_data = 0; hs_be = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        #1;
        check("rst_gnt", {31'b0, host_gnt_o}, 32'd0);
        check("rst_rd_data", host_rd_data_o, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Give the 16 words under test known contents.
        for (int i = 0; i < 16; i++) drive_cycle(32'h0, 32'(i * 4), $urandom, 4'hF);
        chk_ld = 1'b1;

        // Full-word then single-lane core store.
        drive_cycle(32'h10, 32'h10, 32'hDEADBEEF, 4'hF);
        drive_cycle(32'h10, 32'h10, 32'h0000AA00, 4'b0010);
        drive_cycle(32'h10, 32'h0, 32'h0, 4'h0);
        #2 check("merge_load", dram_rd_data_o, 32'hDEADAAEF);

        // Host read: gnt exactly one cycle later, then low with req still held.
        host_start(1'b0, 32'h10, 32'h0, 4'h0);
        drive_cycle(32'h10, 32'h0, 32'h0, 4'h0);
        #2;
        check("read_gnt_n1", {31'b0, host_gnt_o}, 32'd1);
        check("read_data_n1", host_rd_data_o, 32'hDEADAAEF);
        drive_cycle(32'h10, 32'h0, 32'h0, 4'h0);
        #2 check("read_gnt_n2", {31'b0, host_gnt_o}, 32'd0);

        // Host write blocked by three consecutive core stores.
        host_start(1'b1, 32'h20, 32'h12345678, 4'hF);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(32'h20, 32'h20, $urandom, 4'hF);
            #2 check("blocked_gnt", {31'b0, host_gnt_o}, 32'd0);
        end
        drive_cycle(32'h20, 32'h0, 32'h0, 4'h0);
        drive_cycle(32'h20, 32'h0, 32'h0, 4'h0);
        #2 check("write_commit", dram_rd_data_o, 32'h12345678);

        // Host read merging a same-edge core store.
        drive_cycle(32'h30, 32'h30, 32'h11223344, 4'hF);
        host_start(1'b0, 32'h30, 32'h0, 4'h0);
        drive_cycle(32'h30, 32'h30, 32'h000000FF, 4'b0001);
        #2 check("read_merge", host_rd_data_o, 32'h112233FF);
        idle_cycles(2);

        // Reset between acceptance and gnt.
        host_start(1'b0, 32'h20, 32'h0, 4'h0);
        drive_cycle(32'h0, 32'h0, 32'h0, 4'h0);
        #1 rst_n_i = 1'b0;
        #1;
        check("rst_mid_gnt", {31'b0, host_gnt_o}, 32'd0);
        check("rst_mid_rd_data", host_rd_data_o, 32'd0);
        check("rst_mid_err", {31'b0, err_o}, 32'd0);
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        h_resp = 1'b0; last_rd = 32'h0; err_exp = 1'b0;
        idle_cycles(2);
        #2 rst_n_i = 1'b1;
        host_start(1'b0, 32'h30, 32'h0, 4'h0);
        idle_cycles(3);

        // Store above the array range: alias to word 0 or dropped with err.
        drive_cycle(32'h0, 32'h0001_0000, 32'hCAFEF00D, 4'hF);
        drive_cycle(32'h0, 32'h0, 32'h0, 4'h0);
`ifdef DRAM_BOUND_CHK_EN
        #2 check("oob_err", {31'b0, err_o}, 32'd1);
`else
        #2 check("oob_alias", dram_rd_data_o, 32'hCAFEF00D);
`endif

        // Randomized traffic on both ports.
        for (int n = 0; n < 600; n++) begin
            if (!h_pend && !h_resp && $urandom_range(0, 2) == 0) begin
                host_start(1'($urandom_range(0, 1)), rand_addr(), $urandom,
                           ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
            end
            wbe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            drive_cycle(rand_addr(), rand_addr(), $urandom, wbe);
        end
        idle_cycles(6);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
